// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer/depth derivation and Gray conversions,
// used by both the write- and read-side controllers and the synchronizer.
package fifo_pkg;

    localparam int ADDR_WIDTH_DFLT = 4;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Operates on zero-extended values, so callers may pass any width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Enable-gated binary + Gray pointer register pair with synchronous reset.
// Shared by the write- and read-side FIFO controllers.
module gray_counter
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_next_o
);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;

    always_comb begin
        bin_d  = bin_q + WIDTH'(en_i);
        gray_d = WIDTH'(bin2gray(32'(bin_d)));
    end

    // Gray is registered directly so the synchronizer sees a glitch-free flop output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o      = bin_q;
    assign gray_o     = gray_q;
    assign bin_next_o = bin_d;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain control for the async FIFO: write pointer, RAM strobe/address,
// full/almost-full/level and sticky overflow. Level tracking is built only when
// FIFO_WR_CTRL_LEVEL_EN is defined; otherwise full comes from a pointer compare.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DFLT,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_ena_i,
    input  logic [ADDR_WIDTH:0]   rd_ptr_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
    output logic                  full_o,
    output logic                  afull_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o
);

    localparam int PTR_WIDTH = ptr_width(ADDR_WIDTH);
    localparam int DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_bin;
    logic [PTR_WIDTH-1:0] wr_ptr_next;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 unused_ptr_msb;

    assign wr_en_o        = wr_ena_i & ~full_q & ~rst_i;
    assign wr_addr_o      = wr_ptr_bin[ADDR_WIDTH-1:0];
    assign unused_ptr_msb = wr_ptr_bin[PTR_WIDTH-1];

    gray_counter #(
        .WIDTH(PTR_WIDTH)
    ) u_wr_ptr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (wr_en_o),
        .bin_o     (wr_ptr_bin),
        .gray_o    (wr_ptr_gray_o),
        .bin_next_o(wr_ptr_next)
    );

    // Overflow keys off the registered full, i.e. the same flag that blocked the write.
    always_comb begin
        overflow_d = overflow_q | (wr_ena_i & full_q);
    end

`ifdef FIFO_WR_CTRL_LEVEL_EN
    localparam logic [PTR_WIDTH-1:0] AFULL_P = PTR_WIDTH'(AFULL_LEVEL);

    logic [PTR_WIDTH-1:0] lvl_next;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic                 afull_q, afull_d;

    // A stale or bogus read pointer can give lvl_next > DEPTH; saturate rather than wrap.
    always_comb begin
        lvl_next = wr_ptr_next - rd_ptr_i;
        full_d   = (lvl_next >= DEPTH_P);
        afull_d  = (lvl_next >= AFULL_P);
        level_d  = (lvl_next > DEPTH_P) ? DEPTH_P : lvl_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign level_o = level_q;
    assign afull_o = afull_q;
`else
    localparam logic [PTR_WIDTH-1:0] unused_afull_level = PTR_WIDTH'(AFULL_LEVEL);

    // Full when the pointers are exactly one lap apart.
    always_comb begin
        full_d = (wr_ptr_next[PTR_WIDTH-1] != rd_ptr_i[PTR_WIDTH-1])
              && (wr_ptr_next[PTR_WIDTH-2:0] == rd_ptr_i[PTR_WIDTH-2:0]);
    end

    assign level_o = '0;
    assign afull_o = full_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign full_o     = full_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed plan steps plus a randomized
// phase, all compared against a pointer-count reference model.
module tb_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       wr_ena_i;
    logic [4:0] rd_ptr_i;
    logic       wr_en_o;
    logic [3:0] wr_addr_o;
    logic [4:0] wr_ptr_gray_o;
    logic       full_o;
    logic       afull_o;
    logic [4:0] level_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    // reference model state: write count modulo 2*DEPTH, plus flags
    int m_ptr   = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_afull = 0;
    bit m_ovf   = 0;

    logic [31:0] exp_q[$];

    fifo_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .AFULL_LEVEL(AFULL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .wr_ena_i     (wr_ena_i),
        .rd_ptr_i     (rd_ptr_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_ptr_gray_o(wr_ptr_gray_o),
        .full_o       (full_o),
        .afull_o      (afull_o),
        .level_o      (level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational strobe/address, then check the
    // registered outputs one time unit after the edge.
    task automatic step(input bit wr, input int rd, input bit rst);
        bit exp_en;
        int lvl;
        wr_ena_i = wr;
        rd_ptr_i = 5'(rd);
        rst_i    = rst;
        #1;
        exp_en = wr && !m_full && !rst;
        chk("wr_en", 32'(wr_en_o), 32'(exp_en));
        if (!rst) chk("wr_addr", 32'(wr_addr_o), 32'(m_ptr % DEPTH));
        if (exp_en) exp_q.push_back(32'(m_ptr % DEPTH));
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (wr && m_full) m_ovf = 1;
            if (exp_en) m_ptr = (m_ptr + 1) % PMOD;
            lvl = (m_ptr - rd + PMOD) % PMOD;
`ifdef FIFO_WR_CTRL_LEVEL_EN
            m_full  = (lvl >= DEPTH);
            m_afull = (lvl >= AFULL);
            m_level = (lvl > DEPTH) ? DEPTH : lvl;
`else
            m_full  = (lvl == DEPTH);
            m_afull = m_full;
            m_level = 0;
`endif
        end
        #1;
        chk("gray",     32'(wr_ptr_gray_o), 32'(m_ptr ^ (m_ptr >> 1)));
        chk("full",     32'(full_o),        32'(m_full));
        chk("afull",    32'(afull_o),       32'(m_afull));
        chk("level",    32'(level_o),       32'(m_level));
        chk("overflow", 32'(overflow_o),    32'(m_ovf));
    endtask

    initial begin
        logic [4:0] gray_tbl [5];
        int rd;
        gray_tbl = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110};
        rst_i = 1'b1; wr_ena_i = 1'b0; rd_ptr_i = '0;
        @(posedge clk); #1;

        // reset held with writes requested
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        chk("rst_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_gray", 32'(wr_ptr_gray_o), 32'd0);

        // 16 back-to-back writes from empty
        for (int i = 0; i < 16; i++) begin
            if (i < 5) chk("gray_seq", 32'(wr_ptr_gray_o), 32'(gray_tbl[i]));
            step(1, 0, 0);
`ifdef FIFO_WR_CTRL_LEVEL_EN
            if (i == 10) chk("afull_11", 32'(afull_o), 32'd0);
            if (i == 11) chk("afull_12", 32'(afull_o), 32'd1);
`endif
        end
        chk("full_16", 32'(full_o), 32'd1);
`ifdef FIFO_WR_CTRL_LEVEL_EN
        chk("level_16", 32'(level_o), 32'd16);
`endif

        // writes while full are dropped and overflow sticks
        step(1, 0, 0);
        step(1, 0, 0);
        chk("ovf_addr", 32'(wr_addr_o), 32'd0);
        step(0, 0, 0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // read pointer advance releases full
        step(0, 5, 0);
        chk("rel_full", 32'(full_o), 32'd0);
`ifdef FIFO_WR_CTRL_LEVEL_EN
        chk("rel_level", 32'(level_o), 32'd11);
`endif
        chk("rel_addr", 32'(wr_addr_o), 32'd0);
        step(1, 5, 0);

        // advance to pointer 31, then wrap with rd_ptr 28
        for (int i = 0; i < 14; i++) step(1, 16, 0);
        chk("pre_wrap_gray", 32'(wr_ptr_gray_o), 32'h10);
        step(1, 28, 0);
        chk("wrap_gray", 32'(wr_ptr_gray_o), 32'h00);
`ifdef FIFO_WR_CTRL_LEVEL_EN
        chk("wrap_level", 32'(level_o), 32'd4);
`endif

        // randomized traffic with a legal lagging read pointer
        for (int i = 0; i < 300; i++) begin
            rd = (m_ptr - int'($urandom_range(0, DEPTH)) + PMOD) % PMOD;
            step(bit'($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 59) == 0));
        end

        // reset mid-burst at level 7 with overflow set
        step(0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, 0, 0);
        step(1, 9, 0);
        chk("mid_ovf", 32'(overflow_o), 32'd1);
`ifdef FIFO_WR_CTRL_LEVEL_EN
        chk("mid_level", 32'(level_o), 32'd7);
`endif
        step(1, 9, 1);
        chk("mid_gray", 32'(wr_ptr_gray_o), 32'd0);
        chk("mid_addr", 32'(wr_addr_o), 32'd0);

        // accepted-write address stream: first 16 writes hit addresses 0..15
        for (int i = 0; i < 16; i++) begin
            if (exp_q.size() > 0) chk("addr_stream", exp_q.pop_front(), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
